led_bar_monitor: RTL and testbench
==================================

Name: led_bar_monitor

Overview:
- Receive-side checker for the 16-LED thermometer bar driven by the LED sweep controller.
- Samples the bar every clock, decodes it to a level, and tracks sweep direction, turning points and segment count.
- Flags malformed codes and illegal jumps, and pulses when a full sweep returns to rest.
- Sits beside the controller on the board/testbench; outputs feed status LEDs and the verification scoreboard.

Parameters:
- N_LED, 16, bar width; level range 0..N_LED
- LVL_W, 5, level width; must satisfy 2^LVL_W > N_LED
- IDLE_HOLD, 4, consecutive cycles at level 0 in DOWN needed to declare sweep complete

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-low reset
- LED  input  N_LED  thermometer-coded bar from the controller
- level  output  LVL_W  last valid decoded level
- dir  output  2  00 IDLE, 01 UP, 10 DOWN (11 never driven)
- seg_count  output  4  number of turns since sweep start; saturates at 15
- peak  output  LVL_W  level at the most recent UP->DOWN turn
- valley  output  LVL_W  level at the most recent DOWN->UP turn
- turn  output  1  one-cycle pulse on any direction reversal
- cycle_done  output  1  one-cycle pulse on DOWN->IDLE
- code_err  output  1  one-cycle pulse when the sampled LED is not a thermometer code
- jump_err  output  1  one-cycle pulse when the level step magnitude is greater than 1
- err_sticky  output  1  set by code_err or jump_err; cleared only by reset

Behaviour:
Reset (sampled with reset==0 at a rising clk edge):
- led_q=0, level=0, prev=0, dir=IDLE, seg_count=0, peak=0, valley=0, hold_cnt=0.
- All pulse outputs 0; err_sticky=0.

Pipeline:
- Stage 1 registers LED into led_q.
- Stage 2 decodes led_q and updates all outputs.
- An LED change at edge k is visible on the outputs after edge k+1.

Decode:
- led_q is valid iff led_q == 2^n - 1 for some n in 0..N_LED; then n is the new level.
- If invalid: code_err=1 for that cycle. level, dir, counters and hold_cnt are all frozen; the next valid sample is compared against the frozen level.

Step, computed on valid samples only: d = n - level, signed, one bit wider than LVL_W.

State machine (dir):
- IDLE:
  - d=+1 → UP, seg_count=0.
  - d=0 → stay.
  - d>1 → jump_err; level updated; stay IDLE.
  - d<0 cannot occur from level 0.
- UP:
  - d=+1 → stay.
  - d=0 → stay.
  - d=-1 → DOWN; peak=old level; seg_count+1; turn=1.
- DOWN:
  - d=-1 → stay; hold_cnt=0.
  - d=+1 → UP; valley=old level; seg_count+1; turn=1; hold_cnt=0.
  - d=0 with n≠0 → stay; hold_cnt=0.
  - d=0 with n=0 → hold_cnt+1. When hold_cnt reaches IDLE_HOLD-1 and the sample is still 0: → IDLE, cycle_done=1, hold_cnt=0, seg_count held for readout.
- Any state, |d|>1:
  - jump_err=1; level=n.
  - In UP/DOWN, dir is then set by the sign of d; this does not count as a turn and seg_count is unchanged.
- Entering level 0 from DOWN is not itself a turn; a later d=+1 from 0 is a turn (valley=0).

Boundaries and priority:
- level 16 (all ones) is valid; 16→15 is a legal turn.
- seg_count saturates at 15 and never wraps.
- code_err and jump_err are mutually exclusive, because an invalid sample never computes d.
- Reset asserted mid-sweep clears everything on that edge; reset has priority over all updates.

Test Plan:
- Reset, then hold LED=0x0000 for 10 cycles → dir=IDLE, level=0, no pulses, err_sticky=0.
- Ramp LED 0x0001..0xFFFF one step per cycle, then down to 0x003F, then up to 0x07FF → turn pulses twice; peak=16, valley=6; seg_count=2; dir=UP; level=11.
- From DOWN at level 1, step to 0x0000 and hold 4 cycles → cycle_done pulses exactly once, on the 4th zero sample (2 edges later); dir=IDLE; seg_count retained.
- Inject LED=0x0005 mid-ramp at level 3 → code_err one cycle; err_sticky=1; level stays 3; next sample 0x000F is accepted cleanly.
- In UP at level 2, drive LED=0x003F → jump_err one cycle; level=6; dir=UP; seg_count unchanged.
- Assert reset mid-DOWN at level 9 → next edge: all outputs at reset values; sweep tracking restarts from IDLE.

Source files
------------

// File: rtl/led_bar_monitor_if.sv
// Bundle between the LED sweep controller side (master) and the bar monitor (slave).
// Signal names follow the board-level net names of the LED bar.
interface led_bar_monitor_if #(
  parameter int N_LED = 16,
  parameter int LVL_W = 5
);
  logic [N_LED-1:0] LED;
  logic [LVL_W-1:0] level;
  logic [1:0]       dir;
  logic [3:0]       seg_count;
  logic [LVL_W-1:0] peak;
  logic [LVL_W-1:0] valley;
  logic             turn;
  logic             cycle_done;
  logic             code_err;
  logic             jump_err;
  logic             err_sticky;

  modport master (
    output LED,
    input  level, dir, seg_count, peak, valley,
    input  turn, cycle_done, code_err, jump_err, err_sticky
  );

  modport slave (
    input  LED,
    output level, dir, seg_count, peak, valley,
    output turn, cycle_done, code_err, jump_err, err_sticky
  );
endinterface

// File: rtl/led_bar_monitor.sv
// Receive-side checker for a thermometer-coded LED bar: decodes the level, tracks
// sweep direction, turning points and segment count, and flags malformed codes/jumps.
module led_bar_monitor #(
  parameter int N_LED     = 16,
  parameter int LVL_W     = 5,
  parameter int IDLE_HOLD = 4
) (
  input  logic             clk,
  input  logic             reset,
  led_bar_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10
  } dir_e;

  localparam int HOLD_W = $clog2(IDLE_HOLD + 1);
  // The arriving zero sample leaves the counter at 0, so the last one is seen at IDLE_HOLD-2.
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(IDLE_HOLD - 2);
  localparam logic signed [LVL_W:0] D_ONE  = (LVL_W + 1)'(1);

  logic [N_LED-1:0] r_led_q;
  logic [LVL_W-1:0] r_level;
  dir_e             r_dir;
  logic [3:0]       r_seg;
  logic [LVL_W-1:0] r_peak;
  logic [LVL_W-1:0] r_valley;
  logic [HOLD_W-1:0] r_hold;
  logic             r_turn;
  logic             r_done;
  logic             r_cerr;
  logic             r_jerr;
  logic             r_sticky;

  logic [N_LED-1:0]   w_led_inc;
  logic               w_valid;
  logic [LVL_W-1:0]   w_n;
  logic signed [LVL_W:0] w_d;
  logic               w_up1;
  logic               w_dn1;
  logic               w_flat;
  logic               w_jump;
  logic               w_zero;
  logic               w_hold_last;
  logic               w_step_ok;
  dir_e               w_dir_nxt;
  logic               w_turn;
  logic               w_done;
  logic               w_cerr;
  logic               w_jerr;
  logic [3:0]         w_seg_nxt;
  logic [LVL_W-1:0]   w_level_nxt;
  logic [LVL_W-1:0]   w_peak_nxt;
  logic [LVL_W-1:0]   w_valley_nxt;
  logic [HOLD_W-1:0]  w_hold_nxt;

  // A thermometer code plus one has no bit in common with itself (all-ones wraps to 0).
  assign w_led_inc = r_led_q + N_LED'(1);
  assign w_valid   = ((r_led_q & w_led_inc) == '0);

  always_comb begin
    w_n = '0;
    for (int i = 0; i < N_LED; i++) begin
      w_n = w_n + LVL_W'(r_led_q[i]);
    end
  end

  assign w_d         = $signed({1'b0, w_n}) - $signed({1'b0, r_level});
  assign w_up1       = (w_d == D_ONE);
  assign w_dn1       = (w_d == -D_ONE);
  assign w_flat      = (w_d == '0);
  assign w_jump      = !(w_up1 || w_dn1 || w_flat);
  assign w_zero      = (w_n == '0);
  assign w_hold_last = (r_hold >= HOLD_LAST);
  assign w_step_ok   = w_valid && !w_jump;

  // Direction state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_dir <= DIR_IDLE;
    end else begin
      r_dir <= w_dir_nxt;
    end
  end

  // Next-state logic; invalid samples leave the direction frozen.
  always_comb begin
    // NOTE: default first so every path assigns w_dir_nxt and no latch is inferred.
    w_dir_nxt = r_dir;
    if (w_valid) begin
      if (w_jump) begin
        if (r_dir != DIR_IDLE) begin
          w_dir_nxt = w_d[LVL_W] ? DIR_DOWN : DIR_UP;
        end
      end else begin
        case (r_dir)
          DIR_IDLE: if (w_up1) w_dir_nxt = DIR_UP;
          DIR_UP:   if (w_dn1) w_dir_nxt = DIR_DOWN;
          DIR_DOWN: begin
            if (w_up1) begin
              w_dir_nxt = DIR_UP;
            end else if (w_flat && w_zero && w_hold_last) begin
              w_dir_nxt = DIR_IDLE;
            end
          end
          default:  w_dir_nxt = DIR_IDLE;
        endcase
      end
    end
  end

  // Output and datapath next values, derived from the current state and step.
  always_comb begin
    w_cerr       = !w_valid;
    w_jerr       = w_valid && w_jump;
    w_turn       = w_step_ok && (((r_dir == DIR_UP) && w_dn1) || ((r_dir == DIR_DOWN) && w_up1));
    w_done       = w_step_ok && (r_dir == DIR_DOWN) && w_flat && w_zero && w_hold_last;
    w_level_nxt  = w_valid ? w_n : r_level;
    w_peak_nxt   = r_peak;
    w_valley_nxt = r_valley;
    w_seg_nxt    = r_seg;
    w_hold_nxt   = '0;

    if (w_step_ok && (r_dir == DIR_IDLE) && w_up1) begin
      w_seg_nxt = '0;
    end
    if (w_turn) begin
      if (r_seg != 4'd15) w_seg_nxt = r_seg + 4'd1;
      if (r_dir == DIR_UP) w_peak_nxt = r_level;
      else                 w_valley_nxt = r_level;
    end

    if (!w_valid) begin
      w_hold_nxt = r_hold;
    end else if (w_step_ok && (r_dir == DIR_DOWN) && w_flat && w_zero && !w_hold_last) begin
      w_hold_nxt = r_hold + HOLD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_led_q  <= '0;
      r_level  <= '0;
      r_seg    <= '0;
      r_peak   <= '0;
      r_valley <= '0;
      r_hold   <= '0;
      r_turn   <= 1'b0;
      r_done   <= 1'b0;
      r_cerr   <= 1'b0;
      r_jerr   <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      r_led_q  <= bus.LED;
      r_level  <= w_level_nxt;
      r_seg    <= w_seg_nxt;
      r_peak   <= w_peak_nxt;
      r_valley <= w_valley_nxt;
      r_hold   <= w_hold_nxt;
      r_turn   <= w_turn;
      r_done   <= w_done;
      r_cerr   <= w_cerr;
      r_jerr   <= w_jerr;
      r_sticky <= r_sticky || w_cerr || w_jerr;
    end
  end

  assign bus.level      = r_level;
  assign bus.dir        = r_dir;
  assign bus.seg_count  = r_seg;
  assign bus.peak       = r_peak;
  assign bus.valley     = r_valley;
  assign bus.turn       = r_turn;
  assign bus.cycle_done = r_done;
  assign bus.code_err   = r_cerr;
  assign bus.jump_err   = r_jerr;
  assign bus.err_sticky = r_sticky;

endmodule

// File: tb/tb_led_bar_monitor.sv
// Self-checking bench for led_bar_monitor: directed sweeps with literal expectations,
// then a random walk compared every cycle against a level-based behavioural model.
module tb_led_bar_monitor;
  localparam int N_LED     = 16;
  localparam int LVL_W     = 5;
  localparam int IDLE_HOLD = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  led_bar_monitor_if #(.N_LED(N_LED), .LVL_W(LVL_W)) bus ();

  led_bar_monitor #(.N_LED(N_LED), .LVL_W(LVL_W), .IDLE_HOLD(IDLE_HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Model state: direction 0=idle 1=up 2=down, zero-sample run length while falling.
  logic [15:0] m_led_q;
  int m_lvl, m_dir, m_seg, m_peak, m_valley, m_zeros;
  bit m_turn, m_done, m_cerr, m_jerr, m_sticky;

  int n_vec = 0;
  int n_err = 0;
  bit armed = 1'b0;
  int turn_seen = 0, done_seen = 0, cerr_seen = 0, jerr_seen = 0, lvl_at_cerr = -1;

  function automatic bit is_thermo(logic [15:0] v);
    logic [15:0] p;
    p = v + 16'd1;
    return (v & p) == 16'd0;
  endfunction

  function automatic logic [15:0] th(int n);
    logic [16:0] t;
    t = (17'd1 << n) - 17'd1;
    return t[15:0];
  endfunction

  task automatic model_reset();
    m_led_q = '0; m_lvl = 0; m_dir = 0; m_seg = 0; m_peak = 0; m_valley = 0; m_zeros = 0;
    m_turn = 0; m_done = 0; m_cerr = 0; m_jerr = 0; m_sticky = 0;
  endtask

  task automatic model_step();
    int n, d;
    m_turn = 0; m_done = 0; m_cerr = 0; m_jerr = 0;
    if (!is_thermo(m_led_q)) begin
      m_cerr = 1; m_sticky = 1;
      return;
    end
    n = $countones(m_led_q);
    d = n - m_lvl;
    if (d > 1 || d < -1) begin
      m_jerr = 1; m_sticky = 1;
      if (m_dir != 0) begin
        m_dir   = (d > 0) ? 1 : 2;
        m_zeros = (m_dir == 2 && n == 0) ? 1 : 0;
      end
    end else if (m_dir == 0) begin
      if (d == 1) begin m_dir = 1; m_seg = 0; end
    end else if (m_dir == 1) begin
      if (d == -1) begin
        m_dir = 2; m_peak = m_lvl; m_seg = (m_seg < 15) ? m_seg + 1 : 15; m_turn = 1;
        m_zeros = (n == 0) ? 1 : 0;
      end
    end else begin
      if (d == 1) begin
        m_dir = 1; m_valley = m_lvl; m_seg = (m_seg < 15) ? m_seg + 1 : 15; m_turn = 1;
        m_zeros = 0;
      end else if (n == 0) begin
        m_zeros++;
        if (m_zeros == IDLE_HOLD) begin m_dir = 0; m_done = 1; m_zeros = 0; end
      end else begin
        m_zeros = 0;
      end
    end
    m_lvl = n;
  endtask

  task automatic compare();
    bit bad;
    n_vec++;
    bad = (int'(bus.level) != m_lvl) || (int'(bus.dir) != m_dir) || (int'(bus.seg_count) != m_seg) ||
          (int'(bus.peak) != m_peak) || (int'(bus.valley) != m_valley) ||
          (bus.turn !== m_turn) || (bus.cycle_done !== m_done) || (bus.code_err !== m_cerr) ||
          (bus.jump_err !== m_jerr) || (bus.err_sticky !== m_sticky);
    if (bad) begin
      n_err++;
      $display("FAIL cycle_cmp t=%0t got lvl=%0d dir=%0d seg=%0d pk=%0d vl=%0d tdcj=%b%b%b%b st=%b required lvl=%0d dir=%0d seg=%0d pk=%0d vl=%0d tdcj=%b%b%b%b st=%b",
               $time, bus.level, bus.dir, bus.seg_count, bus.peak, bus.valley,
               bus.turn, bus.cycle_done, bus.code_err, bus.jump_err, bus.err_sticky,
               m_lvl, m_dir, m_seg, m_peak, m_valley, m_turn, m_done, m_cerr, m_jerr, m_sticky);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      model_reset();
    end else begin
      model_step();
      m_led_q = bus.LED;
    end
    #1;
    if (armed) compare();
    if (bus.turn === 1'b1)       turn_seen++;
    if (bus.cycle_done === 1'b1) done_seen++;
    if (bus.jump_err === 1'b1)   jerr_seen++;
    if (bus.code_err === 1'b1) begin
      cerr_seen++;
      lvl_at_cerr = int'(bus.level);
    end
  endtask

  task automatic apply(input logic [15:0] v, input logic rn = 1'b1);
    bus.LED = v;
    reset   = rn;
    tick();
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  initial begin
    int t0, d0, c0, j0, lv;
    bus.LED = '0;
    reset   = 1'b0;
    model_reset();

    // Reset, then a quiet bar.
    apply(16'h0000, 1'b0);
    armed = 1'b1;
    apply(16'h0000, 1'b0);
    t0 = turn_seen; d0 = done_seen; c0 = cerr_seen; j0 = jerr_seen;
    repeat (10) apply(16'h0000);
    check("idle_dir", int'(bus.dir), 0);
    check("idle_level", int'(bus.level), 0);
    check("idle_sticky", int'(bus.err_sticky), 0);
    check("idle_pulses", (turn_seen - t0) + (done_seen - d0) + (cerr_seen - c0) + (jerr_seen - j0), 0);

    // Full ramp to 16, down to 6, back up to 11.
    t0 = turn_seen;
    for (int n = 1; n <= 16; n++) apply(th(n));
    for (int n = 15; n >= 6; n--) apply(th(n));
    for (int n = 7; n <= 11; n++) apply(th(n));
    apply(th(11));
    check("ramp_turns", turn_seen - t0, 2);
    check("ramp_peak", int'(bus.peak), 16);
    check("ramp_valley", int'(bus.valley), 6);
    check("ramp_seg", int'(bus.seg_count), 2);
    check("ramp_dir", int'(bus.dir), 1);
    check("ramp_level", int'(bus.level), 11);

    // Fall to rest and hold zero until the sweep completes.
    d0 = done_seen;
    for (int n = 10; n >= 1; n--) apply(th(n));
    repeat (6) apply(16'h0000);
    check("rest_done_once", done_seen - d0, 1);
    check("rest_dir", int'(bus.dir), 0);
    check("rest_seg_kept", int'(bus.seg_count), 3);
    check("rest_peak", int'(bus.peak), 11);

    // Malformed code at level 3, then a clean step to 4.
    c0 = cerr_seen; j0 = jerr_seen;
    apply(th(1)); apply(th(2)); apply(th(3));
    apply(16'h0005);
    apply(th(4)); apply(th(4));
    check("cerr_pulses", cerr_seen - c0, 1);
    check("cerr_no_jerr", jerr_seen - j0, 0);
    check("cerr_level_frozen", lvl_at_cerr, 3);
    check("cerr_sticky", int'(bus.err_sticky), 1);
    check("cerr_level_after", int'(bus.level), 4);

    // Jump 2 -> 6 while rising.
    apply(16'h0000, 1'b0);
    apply(16'h0000); apply(16'h0000);
    j0 = jerr_seen;
    apply(th(1)); apply(th(2)); apply(th(6)); apply(th(6));
    check("jump_pulses", jerr_seen - j0, 1);
    check("jump_level", int'(bus.level), 6);
    check("jump_dir", int'(bus.dir), 1);
    check("jump_seg", int'(bus.seg_count), 0);
    check("jump_sticky", int'(bus.err_sticky), 1);

    // Reset while falling at level 9.
    apply(16'h0000, 1'b0);
    apply(16'h0000); apply(16'h0000);
    for (int n = 1; n <= 12; n++) apply(th(n));
    for (int n = 11; n >= 9; n--) apply(th(n));
    apply(th(9));
    check("pre_rst_dir", int'(bus.dir), 2);
    check("pre_rst_level", int'(bus.level), 9);
    apply(th(9), 1'b0);
    check("rst_level", int'(bus.level), 0);
    check("rst_dir", int'(bus.dir), 0);
    check("rst_seg", int'(bus.seg_count), 0);
    check("rst_peak_valley", int'(bus.peak) + int'(bus.valley), 0);
    check("rst_sticky", int'(bus.err_sticky), 0);
    check("rst_pulses", int'({bus.turn, bus.cycle_done, bus.code_err, bus.jump_err}), 0);
    bus.LED = '0;
    repeat (3) apply(16'h0000);

    // Oscillate 1<->2 long enough to saturate the segment counter.
    apply(th(1));
    for (int k = 0; k < 20; k++) begin
      apply(th(2));
      apply(th(1));
    end
    apply(th(1));
    check("sat_seg", int'(bus.seg_count), 15);
    check("sat_dir", int'(bus.dir), 2);
    check("sat_peak", int'(bus.peak), 2);
    check("sat_valley", int'(bus.valley), 1);

    // Random walk with occasional bad codes, jumps and resets.
    lv = 1;
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] v;
      int r;
      bit rn;
      bit bad;
      r   = int'($urandom_range(0, 99));
      rn  = ($urandom_range(0, 399) != 0);
      bad = 1'b0;
      if (r < 35)      lv = (lv < 16) ? lv + 1 : lv - 1;
      else if (r < 70) lv = (lv > 0) ? lv - 1 : lv;
      else if (r < 85) lv = lv;
      else if (r < 92) bad = 1'b1;
      else             lv = int'($urandom_range(0, 16));
      if (bad) begin
        v = 16'($urandom);
        if (is_thermo(v)) v = 16'h0005;
      end else begin
        v = th(lv);
      end
      apply(v, rn);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
